trid_fetch_engine: RTL and testbench

- One transaction slot that consumes one demuxed request channel (addr/size/start/end/en) of the 16-way request distributor.
- Reads r_size beats from memory and writes w_size beats to the destination address. Each written beat carries a byte strobe that keeps only bytes whose burst-relative index lies in [r_start, r_end]. This is the column extraction.
- Its o_ready drives one bit of the distributor's ready vector; 16 instances sit between the distributor and the memory interconnect.

---
 rtl/trid_fetch_engine.sv | 179 +++++++++++++++++
 tb/tb_trid_fetch_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trid_fetch_engine.sv
// Fetch engine slot: reads r_size beats, writes w_size beats with a byte-strobe column window [r_start, r_end].
// Latency: request -> AR/AW next cycle; one beat per cycle in DATA after one cycle of buffer fill.
// Backpressure: single-entry beat buffer; o_r_ready drops while the buffered beat waits on the W channel.
module trid_fetch_engine #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int IDX_W  = 7
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_r_addr,
    input  logic [4:0]          i_r_size,
    input  logic [IDX_W-1:0]    i_r_start,
    input  logic [IDX_W-1:0]    i_r_end,
    input  logic [ADDR_W-1:0]   i_w_addr,
    input  logic [4:0]          i_w_size,
    output logic                o_ready,
    output logic                o_done,
    output logic                o_err,
    output logic                o_ar_valid,
    input  logic                i_ar_ready,
    output logic [ADDR_W-1:0]   o_ar_addr,
    output logic [3:0]          o_ar_len,
    input  logic                i_r_valid,
    output logic                o_r_ready,
    input  logic [DATA_W-1:0]   i_r_data,
    input  logic [1:0]          i_r_resp,
    input  logic                i_r_last,
    output logic                o_aw_valid,
    input  logic                i_aw_ready,
    output logic [ADDR_W-1:0]   o_aw_addr,
    output logic [3:0]          o_aw_len,
    output logic                o_w_valid,
    input  logic                i_w_ready,
    output logic [DATA_W-1:0]   o_w_data,
    output logic [DATA_W/8-1:0] o_w_strb,
    output logic                o_w_last,
    input  logic                i_b_valid,
    output logic                o_b_ready,
    input  logic [1:0]          i_b_resp
);
    localparam int LANES    = DATA_W / 8;
    localparam int CW       = IDX_W + 2;
    // Beats at or beyond this index lie entirely past the largest byte index.
    localparam int MAX_BEAT = (1 << IDX_W) / LANES;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
    logic [4:0]          r_size_q, w_size_q;
    logic [3:0]          ar_len_q, aw_len_q;
    logic [IDX_W-1:0]    start_q, end_q;
    logic                ar_vld_q, aw_vld_q;
    logic [4:0]          rb_q, wb_q, rb_d, wb_d;
    logic                buf_vld_q;
    logic [DATA_W-1:0]   buf_dat_q;
    logic                err_q, bad_q;
    logic                req_bad, accept, r_hs, w_hs, b_hs, in_data;
    logic [CW-1:0]       idx;

    // The last flag is redundant: beat counts drive all control.
    logic unused_r_last;
    assign unused_r_last = i_r_last;

    assign req_bad = (i_r_size == 5'd0) || (i_r_size > 5'd16) ||
                     (i_w_size == 5'd0) || (i_w_size > 5'd16);
    assign accept  = (state_q == S_IDLE) && i_en;
    assign in_data = (state_q == S_DATA);

    assign o_ready    = (state_q == S_IDLE);
    assign o_ar_valid = ar_vld_q;
    assign o_aw_valid = aw_vld_q;
    assign o_ar_addr  = r_addr_q;
    assign o_aw_addr  = w_addr_q;
    assign o_ar_len   = ar_len_q;
    assign o_aw_len   = aw_len_q;
    assign o_b_ready  = (state_q == S_RESP);
    assign o_done     = (state_q == S_DONE) || bad_q;
    assign o_err      = (state_q == S_DONE) ? err_q : bad_q;

    // Write side: buffered beat, or a zero pad beat once every read beat has arrived.
    assign o_w_valid = in_data && (wb_q < w_size_q) && (buf_vld_q || (rb_q == r_size_q));
    assign w_hs      = o_w_valid && i_w_ready;
    assign o_w_data  = (o_w_valid && buf_vld_q) ? buf_dat_q : '0;
    assign o_w_last  = o_w_valid && (wb_q == w_size_q - 5'd1);

    // Read side: fill an empty (or draining) buffer, or swallow beats no write will carry.
    assign o_r_ready = in_data && (rb_q < r_size_q) &&
                       (!buf_vld_q || w_hs || (rb_q >= w_size_q));
    assign r_hs      = i_r_valid && o_r_ready;
    assign b_hs      = i_b_valid && o_b_ready;

    assign rb_d = rb_q + {4'd0, r_hs};
    assign wb_d = wb_q + {4'd0, w_hs};

    // Column strobe: keep lanes whose burst-relative byte index lies inside [start, end].
    always_comb begin
        o_w_strb = '0;
        idx      = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = CW'(wb_q) * CW'(LANES) + CW'(l);
            o_w_strb[l] = o_w_valid && buf_vld_q && (int'(wb_q) < MAX_BEAT) &&
                          (idx >= {2'b00, start_q}) && (idx <= {2'b00, end_q});
        end
    end

    // Next-state logic for the transaction sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_en && !req_bad) state_d = S_ADDR;
            S_ADDR: if ((!ar_vld_q || i_ar_ready) && (!aw_vld_q || i_aw_ready)) state_d = S_DATA;
            S_DATA: if ((wb_d == w_size_q) && (rb_d == r_size_q)) state_d = S_RESP;
            S_RESP: if (i_b_valid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Request capture, address valids, beat counters, beat buffer and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr_q  <= '0;
            w_addr_q  <= '0;
            r_size_q  <= '0;
            w_size_q  <= '0;
            ar_len_q  <= '0;
            aw_len_q  <= '0;
            start_q   <= '0;
            end_q     <= '0;
            ar_vld_q  <= 1'b0;
            aw_vld_q  <= 1'b0;
            rb_q      <= '0;
            wb_q      <= '0;
            buf_vld_q <= 1'b0;
            buf_dat_q <= '0;
            err_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            bad_q <= accept && req_bad;
            if (accept && !req_bad) begin
                r_addr_q  <= i_r_addr;
                w_addr_q  <= i_w_addr;
                r_size_q  <= i_r_size;
                w_size_q  <= i_w_size;
                ar_len_q  <= 4'(i_r_size - 5'd1);
                aw_len_q  <= 4'(i_w_size - 5'd1);
                start_q   <= i_r_start;
                end_q     <= i_r_end;
                ar_vld_q  <= 1'b1;
                aw_vld_q  <= 1'b1;
                rb_q      <= '0;
                wb_q      <= '0;
                buf_vld_q <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                if (ar_vld_q && i_ar_ready) ar_vld_q <= 1'b0;
                if (aw_vld_q && i_aw_ready) aw_vld_q <= 1'b0;
                rb_q <= rb_d;
                wb_q <= wb_d;
                if (r_hs && (rb_q < w_size_q)) begin
                    buf_dat_q <= i_r_data;
                    buf_vld_q <= 1'b1;
                end else if (w_hs) begin
                    buf_vld_q <= 1'b0;
                end
                if ((r_hs && (i_r_resp != 2'd0)) || (b_hs && (i_b_resp != 2'd0))) err_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_trid_fetch_engine.sv
// Self-checking bench: directed cases then randomized transactions against a byte-index reference model.
// Latency: checks done timing for fully-ready cases; otherwise bounded per-transaction cycle budget.
// Backpressure: random/patterned readies and valids, with stall-stability checks on the W channel.
module tb_trid_fetch_engine;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int IDX_W  = 7;
    localparam int LANES  = 16;
    localparam int BUDGET = 400;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_en;
    logic [ADDR_W-1:0]  i_r_addr, i_w_addr;
    logic [4:0]         i_r_size, i_w_size;
    logic [IDX_W-1:0]   i_r_start, i_r_end;
    logic               o_ready, o_done, o_err;
    logic               o_ar_valid, i_ar_ready, o_aw_valid, i_aw_ready;
    logic [ADDR_W-1:0]  o_ar_addr, o_aw_addr;
    logic [3:0]         o_ar_len, o_aw_len;
    logic               i_r_valid, o_r_ready, i_r_last;
    logic [DATA_W-1:0]  i_r_data;
    logic [1:0]         i_r_resp, i_b_resp;
    logic               o_w_valid, i_w_ready, o_w_last;
    logic [DATA_W-1:0]  o_w_data;
    logic [LANES-1:0]   o_w_strb;
    logic               i_b_valid, o_b_ready;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    trid_fetch_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(i_en),
        .i_r_addr(i_r_addr), .i_r_size(i_r_size), .i_r_start(i_r_start), .i_r_end(i_r_end),
        .i_w_addr(i_w_addr), .i_w_size(i_w_size),
        .o_ready(o_ready), .o_done(o_done), .o_err(o_err),
        .o_ar_valid(o_ar_valid), .i_ar_ready(i_ar_ready), .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len),
        .i_r_valid(i_r_valid), .o_r_ready(o_r_ready), .i_r_data(i_r_data), .i_r_resp(i_r_resp),
        .i_r_last(i_r_last),
        .o_aw_valid(o_aw_valid), .i_aw_ready(i_aw_ready), .o_aw_addr(o_aw_addr), .o_aw_len(o_aw_len),
        .o_w_valid(o_w_valid), .i_w_ready(i_w_ready), .o_w_data(o_w_data), .o_w_strb(o_w_strb),
        .o_w_last(o_w_last),
        .i_b_valid(i_b_valid), .o_b_ready(o_b_ready), .i_b_resp(i_b_resp)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        i_en = 0; i_r_addr = 0; i_w_addr = 0; i_r_size = 0; i_w_size = 0;
        i_r_start = 0; i_r_end = 0; i_ar_ready = 0; i_aw_ready = 0;
        i_r_valid = 0; i_r_data = 0; i_r_resp = 0; i_r_last = 0;
        i_w_ready = 0; i_b_valid = 0; i_b_resp = 0;
    endtask

    // Reference: lane l of write beat k is kept when its byte index k*16+l is in [st, en_]
    // and the beat carries real read data in the first 128 bytes.
    function automatic logic [15:0] model_strb(int k, int rs, int st, int en_);
        logic [15:0] s;
        int idx;
        s = '0;
        for (int l = 0; l < LANES; l++) begin
            idx  = k * LANES + l;
            s[l] = (k < rs) && (k < 8) && (idx >= st) && (idx <= en_);
        end
        return s;
    endfunction

    // One transaction. rnd: random AR/AW/R/B handshakes and request noise while busy.
    // wmode: 0 ready always, 1 random, 2 pattern 1-0-0-1. errb: read beat with bad resp (-1 none).
    // abort_w >= 0 returns as soon as that many W beats have been written.
    task automatic run_txn(input int rs, input int ws, input int st, input int en_,
                           input bit rnd, input int wmode, input int errb,
                           input logic [1:0] bres, input int abort_w, output int done_cyc);
        logic [127:0] rdata [16];
        logic [127:0] wq_d [$];
        logic [15:0]  wq_s [$];
        logic         wq_l [$];
        logic [31:0]  ra, wa;
        int rsent, wsent, arhs, awhs, occ, ndone;
        logic exp_err, got_err, w_stalled, rhold, bhold, whs;
        logic [127:0] st_dat;
        logic [15:0]  st_strb;
        string tag;

        ra = $urandom; wa = $urandom;
        for (int k = 0; k < 16; k++) rdata[k] = {$urandom, $urandom, $urandom, $urandom};
        rsent = 0; wsent = 0; arhs = 0; awhs = 0; ndone = 0; done_cyc = -1;
        exp_err = (bres != 2'd0); got_err = 0; w_stalled = 0; rhold = 0; bhold = 0;
        st_dat = 0; st_strb = 0;

        @(negedge clk);
        i_en = 1; i_r_addr = ra; i_w_addr = wa; i_r_size = 5'(rs); i_w_size = 5'(ws);
        i_r_start = 7'(st); i_r_end = 7'(en_);
        #1 chk("ready_idle", o_ready, 1);
        @(negedge clk);
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            i_en = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (rnd) begin
                i_r_addr = $urandom; i_w_addr = $urandom;
                i_r_size = 5'($urandom_range(0, 16)); i_w_size = 5'($urandom_range(0, 16));
                i_r_start = 7'($urandom); i_r_end = 7'($urandom);
            end
            i_ar_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            i_aw_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rhold) i_r_valid = 1;
            else i_r_valid = (arhs > 0) && (rsent < rs) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            i_r_data = (rsent < 16) ? rdata[rsent] : '0;
            i_r_resp = (rsent == errb) ? 2'd2 : 2'd0;
            i_r_last = (rsent == rs - 1);
            case (wmode)
                0: i_w_ready = 1;
                1: i_w_ready = 1'($urandom_range(0, 1));
                default: i_w_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            if (bhold) i_b_valid = 1;
            else i_b_valid = (wsent == ws) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            i_b_resp = bres;
            #1;
            if (cyc == 0) begin
                chk("ready_fall", o_ready, 0);
                chk("ar_valid", o_ar_valid, 1);
                chk("aw_valid", o_aw_valid, 1);
                chk("ar_len", o_ar_len, rs - 1);
                chk("aw_len", o_aw_len, ws - 1);
            end
            if (o_ar_valid && i_ar_ready) begin arhs++; chk("ar_addr", o_ar_addr, ra); end
            if (o_aw_valid && i_aw_ready) begin awhs++; chk("aw_addr", o_aw_addr, wa); end
            whs = o_w_valid && i_w_ready;
            occ = ((rsent < ws) ? rsent : ws) - ((wsent < rs) ? wsent : rs);
            if (occ == 1 && !whs && rsent < ws) chk("r_ready_stall", o_r_ready, 0);
            if (w_stalled) begin
                chk("w_hold_valid", o_w_valid, 1);
                chk("w_hold_data", o_w_data, st_dat);
                chk("w_hold_strb", o_w_strb, st_strb);
            end
            w_stalled = o_w_valid && !i_w_ready;
            st_dat = o_w_data; st_strb = o_w_strb;
            if (whs) begin
                wq_d.push_back(o_w_data); wq_s.push_back(o_w_strb); wq_l.push_back(o_w_last);
                wsent++;
            end
            rhold = i_r_valid && !o_r_ready;
            if (i_r_valid && o_r_ready) rsent++;
            bhold = i_b_valid && !o_b_ready;
            if (o_done) begin ndone++; got_err = o_err; done_cyc = cyc; end
            if (abort_w >= 0 && wsent >= abort_w) return;
            if (o_done) break;
            @(negedge clk);
        end
        if (errb >= 0 && errb < rs) exp_err = 1;
        chk("done_seen", ndone, 1);
        chk("err_at_done", got_err, exp_err);
        chk("ar_count", arhs, 1);
        chk("aw_count", awhs, 1);
        chk("r_beats", rsent, rs);
        chk("w_beats", wsent, ws);
        for (int k = 0; k < ws && k < wq_d.size(); k++) begin
            tag = $sformatf("w%0d", k);
            chk({tag, "_data"}, wq_d[k], (k < rs) ? rdata[k] : 128'd0);
            chk({tag, "_strb"}, wq_s[k], model_strb(k, rs, st, en_));
            chk({tag, "_last"}, wq_l[k], k == ws - 1);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("done_one_cycle", o_done, 0);
        chk("ready_after", o_ready, 1);
    endtask

    task automatic bad_size(input int rs, input int ws);
        @(negedge clk);
        i_en = 1; i_r_size = 5'(rs); i_w_size = 5'(ws); i_r_addr = $urandom; i_w_addr = $urandom;
        @(negedge clk);
        i_en = 0;
        #1;
        chk("bad_done", o_done, 1);
        chk("bad_err", o_err, 1);
        chk("bad_no_ar", o_ar_valid, 0);
        chk("bad_no_aw", o_aw_valid, 0);
        chk("bad_ready", o_ready, 1);
        @(negedge clk);
        #1;
        chk("bad_done_drop", o_done, 0);
        chk("bad_still_no_ar", o_ar_valid, 0);
    endtask

    initial begin
        int dc;
        int rs, ws, eb;
        logic [1:0] br;
        logic seen;
        idle_inputs();
        #2;
        chk("rst_ready", o_ready, 1);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_valids", {o_ar_valid, o_aw_valid, o_w_valid, o_r_ready, o_b_ready}, 0);
        chk("rst_strb", o_w_strb, 0);
        chk("rst_len", {o_ar_len, o_aw_len}, 0);
        @(negedge clk);
        rst_n = 1;

        run_txn(2, 2, 4, 19, 0, 0, -1, 2'd0, -1, dc);
        chk("basic_latency", dc, 5);
        chk("basic_strb0_const", model_strb(0, 2, 4, 19), 16'hFFF0);
        chk("basic_strb1_const", model_strb(1, 2, 4, 19), 16'h000F);
        run_txn(4, 2, 0, 127, 0, 0, -1, 2'd0, -1, dc);
        chk("discard_latency", dc, 6);
        run_txn(1, 3, 0, 127, 0, 0, -1, 2'd0, -1, dc);
        chk("pad_latency", dc, 6);
        run_txn(4, 4, 0, 127, 0, 2, -1, 2'd0, -1, dc);
        run_txn(3, 3, 20, 10, 0, 0, -1, 2'd0, -1, dc);
        run_txn(16, 16, 100, 127, 0, 0, -1, 2'd0, -1, dc);
        bad_size(0, 4);
        bad_size(3, 0);
        run_txn(2, 2, 0, 127, 0, 0, 0, 2'd0, -1, dc);
        run_txn(2, 3, 0, 127, 0, 0, -1, 2'd2, -1, dc);

        // Asynchronous reset in the middle of DATA.
        run_txn(4, 4, 0, 127, 0, 0, -1, 2'd0, 2, dc);
        #2 rst_n = 0;
        #1;
        chk("arst_w_valid", o_w_valid, 0);
        chk("arst_r_ready", o_r_ready, 0);
        chk("arst_addr_valids", {o_ar_valid, o_aw_valid}, 0);
        chk("arst_b_done", {o_b_ready, o_done}, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 if (o_done) seen = 1;
        end
        chk("arst_no_done", seen, 0);
        chk("arst_ready", o_ready, 1);

        for (int t = 0; t < 30; t++) begin
            rs = $urandom_range(1, 16);
            ws = $urandom_range(1, 16);
            eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rs - 1) : -1;
            br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            run_txn(rs, ws, $urandom_range(0, 127), $urandom_range(0, 127),
                    1, $urandom_range(0, 2), eb, br, -1, dc);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
